orientation_math_seq: RTL and testbench
=======================================

ORIENTATION_MATH_SEQ -- requirements
Module: orientation_math_seq

Interface
REQ-001 SHALL have parameter R_W, default 8, meaning radius width in bits.
REQ-002 SHALL have parameter ORIENT_STEPS, default 24, meaning orientation resolution in steps per 360 deg; must be a multiple of 4, at least 8.
REQ-003 SHALL have parameter ERROR_FACTOR, default 4, meaning the axis-shortcut threshold in radius units.
REQ-004 SHALL have parameter FRAC_W, default 6, meaning the tangent LUT fraction bits.
REQ-005 SHALL have port clock, input, 1, meaning the single clock.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset sampled on the rising edge of clock.
REQ-007 SHALL have port enable, input, 1, meaning start request.
REQ-008 SHALL have port r_theta_original, input, R_W+4, meaning theta index in [R_W+3:R_W] and r in [R_W-1:0].
REQ-009 SHALL have port r_theta_final, input, R_W+4, meaning the same encoding for the final point.
REQ-010 SHALL have port busy, output, 1, meaning a computation is in progress.
REQ-011 SHALL have port done, output, 1, meaning the result is valid.
REQ-012 SHALL have port orientation, output, clog2(ORIENT_STEPS), meaning heading in steps.
REQ-013 SHALL have port residual, output, R_W, meaning the best |dy - dx*tan| saturated to all-ones.
REQ-014 SHALL have port no_motion, output, 1, meaning both |dx| and |dy| are at most ERROR_FACTOR.

Function
REQ-015 SHALL, in IDLE, accept enable: busy<=1, done<=0, goto SHORTCUT; enable SHALL be ignored while busy=1; inputs SHALL be held stable by the source until done.
REQ-016 SHALL map theta index t to beam angle BA(t)=(2t+1)*ORIENT_STEPS/24 steps.
REQ-017 SHORTCUT SHALL, on equal theta indices, set orientation=BA(t), plus ORIENT_STEPS/2 if r_original>r_final, residual=0, and goto REPORT; otherwise goto PTC.
REQ-018 SHALL move through states PTC (latch x,y of both points), DELTAS (dx,dy, signed R_W+2 bits), then ABS_QUAD (latch |dx|, |dy| and quadrant Q0..Q3 from the signs, with zero treated as positive).
REQ-019 AXIS SHALL, when |dx|<=EF and |dy|<=EF, set no_motion=1, keep orientation, and goto REPORT.
REQ-020 AXIS SHALL, else when |dy|<=EF, set orientation=0 or ORIENT_STEPS/2 (dx<0), residual=|dy|, and goto REPORT.
REQ-021 AXIS SHALL, else when |dx|<=EF, set orientation=ORIENT_STEPS/4 or 3*ORIENT_STEPS/4 (dy<0), residual=|dx|, and goto REPORT.
REQ-022 AXIS SHALL otherwise clear no_motion and goto SEARCH.
REQ-023 SEARCH SHALL evaluate one candidate k per cycle for k=1..ORIENT_STEPS/4-1, computing d=|(|dx|*TAN[k])>>FRAC_W - |dy||.
REQ-024 SEARCH SHALL replace the running minimum only if d is strictly less, so the lowest k wins ties.
REQ-025 COMBINE SHALL set orientation for the best k by quadrant: Q0 k, Q1 N/2-k, Q2 N/2+k, Q3 N-k.
REQ-026 REPORT SHALL reduce orientation modulo ORIENT_STEPS, set done<=1, busy<=0, and goto IDLE; done SHALL stay high until the next accepted enable.
REQ-027 Latency from the enable-sampling edge to done high SHALL be: shortcut 2 cycles, axis/no-motion 6 cycles, general ORIENT_STEPS/4+6 cycles (12 at default).
REQ-028 Products SHALL be computed at full width, and residual SHALL saturate at 2^R_W-1.

Reset
REQ-029 reset SHALL force state=IDLE, busy=0, done=0, orientation=0, residual=0, and no_motion=0 on the next edge from any state, including mid-SEARCH.
REQ-030 reset SHALL take priority over enable in the same cycle.

Configuration
REQ-031 With ORIENT_SHORTCUT_EN defined, SHORTCUT SHALL behave per REQ-017.
REQ-032 Without ORIENT_SHORTCUT_EN, SHORTCUT SHALL always goto PTC, so equal-theta inputs take the general path with unchanged latency rules otherwise.

Structure
REQ-033 Package orient_pkg SHALL hold the state enum, the sin/cos LUTs for beam angles, the TAN[k] LUT (FRAC_W fixed point), and the BA() function.
REQ-034 Sub-module polar_to_cartesian_p (combinational, parametrised by R_W) SHALL be instantiated twice.

Verification (R_W=8, N=24, EF=4, shortcut on)
REQ-035 Theta 2/2, r 50->80: orientation=5, residual=0, done 2 cycles after enable; r 80->50: orientation=17.
REQ-036 Theta 0 r=100 -> theta 5 r=100 (dx=-194, dy=0): orientation=12, done after 6 cycles.
REQ-037 Theta 0 r=0 -> theta 1 r=100 (dx=dy=71): orientation=3, residual<=1, done after 12 cycles.
REQ-038 Theta 0 r=0 -> theta 3 r=3: no_motion=1, orientation unchanged from the previous result.
REQ-039 Reset pulsed on cycle 8 of a general run: next edge busy=0, done=0, orientation=0; an enable pulse asserted while busy produces no restart and no change in latency.

Source files
------------

// File: rtl/orient_pkg.sv
// Shared types and lookup tables for the orientation datapath: FSM states, beam
// trig tables (Q1.14), tangent table (Q.16) and the beam-angle mapping.
package orient_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_SHORTCUT, S_PTC, S_DELTAS, S_ABS_QUAD,
    S_AXIS, S_SEARCH, S_COMBINE, S_REPORT
  } state_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

  localparam int TRIG_FRAC = 14;
  localparam int TAN_FRAC  = 16;

  // Beam t sits at (2t+1)*15 deg; indices 12..15 are not valid beams.
  localparam logic signed [15:0] COS_LUT [16] = '{
    16'sd15826,  16'sd11585,  16'sd4240,  -16'sd4240,
    -16'sd11585, -16'sd15826, -16'sd15826, -16'sd11585,
    -16'sd4240,  16'sd4240,   16'sd11585,  16'sd15826,
    16'sd0, 16'sd0, 16'sd0, 16'sd0
  };
  localparam logic signed [15:0] SIN_LUT [16] = '{
    16'sd4240,   16'sd11585,  16'sd15826,  16'sd15826,
    16'sd11585,  16'sd4240,   -16'sd4240,  -16'sd11585,
    -16'sd15826, -16'sd15826, -16'sd11585, -16'sd4240,
    16'sd0, 16'sd0, 16'sd0, 16'sd0
  };

  // tan(0,15,30,45,60,75 deg); exact for step counts that divide 24 steps.
  localparam int TAN_LUT [6] = '{0, 17560, 37837, 65536, 113512, 244584};

  function automatic int ba(input int t, input int n);
    return (2 * t + 1) * n / 24;
  endfunction

  function automatic int tan_q(input int k, input int n, input int frac_w);
    int idx;
    int v;
    idx = k * 24 / n;
    if (idx > 5) idx = 5;
    v = TAN_LUT[idx];
    if (frac_w >= TAN_FRAC) return v <<< (frac_w - TAN_FRAC);
    return (v + (1 <<< (TAN_FRAC - frac_w - 1))) >>> (TAN_FRAC - frac_w);
  endfunction

endpackage

// File: rtl/polar_to_cartesian_p.sv
// Combinational polar-to-cartesian conversion of one (beam index, range) point,
// rounded to the nearest integer (half toward +inf).
module polar_to_cartesian_p
  import orient_pkg::*;
#(
  parameter int R_W = 8
) (
  input  logic [3:0]          theta,
  input  logic [R_W-1:0]      r,
  output logic signed [R_W:0] x,
  output logic signed [R_W:0] y
);
  localparam int PW = R_W + 17;

  function automatic logic signed [R_W:0] round_q(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = (p + PW'(1 << (TRIG_FRAC - 1))) >>> TRIG_FRAC;
    return t[R_W:0];
  endfunction

  logic signed [R_W:0]  r_s;
  logic signed [PW-1:0] px;
  logic signed [PW-1:0] py;

  assign r_s = $signed({1'b0, r});
  assign px  = PW'(r_s) * PW'(COS_LUT[theta]);
  assign py  = PW'(r_s) * PW'(SIN_LUT[theta]);
  assign x   = round_q(px);
  assign y   = round_q(py);

endmodule

// File: rtl/orientation_math_seq.sv
// Sequential heading estimator between two polar (beam, range) points.
// Define ORIENT_SHORTCUT_EN to resolve equal-beam inputs directly from the beam angle.
module orientation_math_seq
  import orient_pkg::*;
#(
  parameter int R_W          = 8,
  parameter int ORIENT_STEPS = 24,
  parameter int ERROR_FACTOR = 4,
  parameter int FRAC_W       = 6
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [R_W+3:0]                  r_theta_original,
  input  logic [R_W+3:0]                  r_theta_final,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(ORIENT_STEPS)-1:0] orientation,
  output logic [R_W-1:0]                  residual,
  output logic                            no_motion
);
  localparam int OW = $clog2(ORIENT_STEPS);
  localparam int AW = OW + 1;
  localparam int QN = ORIENT_STEPS / 4;
  localparam int KW = $clog2(QN);
  localparam int DW = R_W + 2;
  localparam int MW = R_W + 1;
  localparam int TW = FRAC_W + 3;
  localparam int PW = MW + TW;
  localparam logic [AW-1:0] HALF = AW'(ORIENT_STEPS / 2);
  localparam logic [AW-1:0] QTR  = AW'(ORIENT_STEPS / 4);
  localparam logic [AW-1:0] FULL = AW'(ORIENT_STEPS);
  localparam logic [MW-1:0] EF   = MW'(ERROR_FACTOR);

  function automatic logic [R_W-1:0] sat_res(input logic [PW-1:0] v);
    return (|v[PW-1:R_W]) ? '1 : v[R_W-1:0];
  endfunction

  function automatic logic [MW-1:0] abs_m(input logic signed [DW-1:0] v);
    return v[DW-1] ? MW'(-v) : MW'(v);
  endfunction

  // Raw headings stay below 2*ORIENT_STEPS, so one conditional subtract wraps them.
  function automatic logic [OW-1:0] wrap_orient(input logic [AW-1:0] v);
    return (v >= FULL) ? OW'(v - FULL) : OW'(v);
  endfunction

  logic [3:0]     theta_o, theta_f;
  logic [R_W-1:0] r_o, r_f;
  assign theta_o = r_theta_original[R_W+3:R_W];
  assign theta_f = r_theta_final[R_W+3:R_W];
  assign r_o     = r_theta_original[R_W-1:0];
  assign r_f     = r_theta_final[R_W-1:0];

  logic shortcut_hit;
`ifdef ORIENT_SHORTCUT_EN
  assign shortcut_hit = (theta_o == theta_f);
`else
  assign shortcut_hit = 1'b0;
`endif

  logic signed [R_W:0] xo_c, yo_c, xf_c, yf_c;
  polar_to_cartesian_p #(.R_W(R_W)) u_ptc_orig (.theta(theta_o), .r(r_o), .x(xo_c), .y(yo_c));
  polar_to_cartesian_p #(.R_W(R_W)) u_ptc_fin  (.theta(theta_f), .r(r_f), .x(xf_c), .y(yf_c));

  logic [TW-1:0] tan_tab [QN];
  logic [AW-1:0] ba_tab [16];
  for (genvar g = 0; g < QN; g++) begin : g_tan
    assign tan_tab[g] = TW'(tan_q(g, ORIENT_STEPS, FRAC_W));
  end
  for (genvar g = 0; g < 16; g++) begin : g_ba
    assign ba_tab[g] = AW'(ba(g, ORIENT_STEPS));
  end

  state_t              state;
  quad_t               quad;
  logic signed [R_W:0] xo, yo, xf, yf;
  logic signed [DW-1:0] dx, dy;
  logic [MW-1:0]       adx, ady;
  logic [KW-1:0]       k, best_k;
  logic [PW-1:0]       best_d;
  logic [AW-1:0]       orient_raw;
  logic [R_W-1:0]      res_raw;

  logic [PW-1:0] prod_c, quot_c, d_c;
  assign prod_c = PW'(adx) * PW'(tan_tab[k]);
  assign quot_c = prod_c >> FRAC_W;
  assign d_c    = (quot_c >= PW'(ady)) ? quot_c - PW'(ady) : PW'(ady) - quot_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      orientation <= '0;
      residual    <= '0;
      no_motion   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            orient_raw <= AW'(orientation);
            res_raw    <= residual;
            state      <= S_SHORTCUT;
          end
        end
        S_SHORTCUT: begin
          if (shortcut_hit) begin
            orient_raw <= ba_tab[theta_o] + ((r_o > r_f) ? HALF : '0);
            res_raw    <= '0;
            state      <= S_REPORT;
          end else begin
            state <= S_PTC;
          end
        end
        // ---- latch cartesian points ----
        S_PTC: begin
          xo    <= xo_c;
          yo    <= yo_c;
          xf    <= xf_c;
          yf    <= yf_c;
          state <= S_DELTAS;
        end
        // ---- signed displacement ----
        S_DELTAS: begin
          dx    <= DW'(xf) - DW'(xo);
          dy    <= DW'(yf) - DW'(yo);
          state <= S_ABS_QUAD;
        end
        // ---- magnitudes and quadrant (zero counts as positive) ----
        S_ABS_QUAD: begin
          adx <= abs_m(dx);
          ady <= abs_m(dy);
          case ({dx[DW-1], dy[DW-1]})
            2'b00:   quad <= Q0;
            2'b10:   quad <= Q1;
            2'b11:   quad <= Q2;
            default: quad <= Q3;
          endcase
          state <= S_AXIS;
        end
        S_AXIS: begin
          no_motion <= 1'b0;
          if (adx <= EF && ady <= EF) begin
            no_motion <= 1'b1;
            state     <= S_REPORT;
          end else if (ady <= EF) begin
            orient_raw <= dx[DW-1] ? HALF : '0;
            res_raw    <= sat_res(PW'(ady));
            state      <= S_REPORT;
          end else if (adx <= EF) begin
            orient_raw <= dy[DW-1] ? HALF + QTR : QTR;
            res_raw    <= sat_res(PW'(adx));
            state      <= S_REPORT;
          end else begin
            k      <= KW'(1);
            best_k <= KW'(1);
            best_d <= '1;
            state  <= S_SEARCH;
          end
        end
        // ---- one tangent candidate per cycle; strict compare keeps lowest k on ties ----
        S_SEARCH: begin
          if (d_c < best_d) begin
            best_d <= d_c;
            best_k <= k;
          end
          if (k == KW'(QN - 1)) state <= S_COMBINE;
          else                  k     <= k + KW'(1);
        end
        S_COMBINE: begin
          case (quad)
            Q0:      orient_raw <= AW'(best_k);
            Q1:      orient_raw <= HALF - AW'(best_k);
            Q2:      orient_raw <= HALF + AW'(best_k);
            default: orient_raw <= FULL - AW'(best_k);
          endcase
          res_raw <= sat_res(best_d);
          state   <= S_REPORT;
        end
        // ---- publish result ----
        S_REPORT: begin
          orientation <= wrap_orient(orient_raw);
          residual    <= res_raw;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_orientation_math_seq.sv
// Directed, table-driven bench for orientation_math_seq at R_W=8, 24 steps, EF=4, FRAC_W=6.
module tb_orientation_math_seq;
  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] r_theta_original;
  logic [11:0] r_theta_final;
  logic        busy;
  logic        done;
  logic [4:0]  orientation;
  logic [7:0]  residual;
  logic        no_motion;

  int passes = 0;
  int total  = 0;

`ifdef ORIENT_SHORTCUT_EN
  localparam int SC_LAT = 2;
`else
  localparam int SC_LAT = 12;
`endif

  orientation_math_seq #(
    .R_W(8), .ORIENT_STEPS(24), .ERROR_FACTOR(4), .FRAC_W(6)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .r_theta_original(r_theta_original), .r_theta_final(r_theta_final),
    .busy(busy), .done(done), .orientation(orientation),
    .residual(residual), .no_motion(no_motion)
  );

  always #5 clock = ~clock;

  typedef struct {
    int to; int ro; int tf; int rf;
    int lat; int orient; int res; int nm; int chk_res;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run(input int to, input int ro, input int tf, input int rf, output int lat);
    r_theta_original = {4'(to), 8'(ro)};
    r_theta_final    = {4'(tf), 8'(rf)};
    enable = 1'b1;
    tick();
    enable = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 40);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    enable = 1'b0;
    r_theta_original = '0;
    r_theta_final = '0;
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_orientation", orientation, 0);
    check("reset_residual", residual, 0);
    check("reset_no_motion", no_motion, 0);
    reset = 1'b0;
    tick();

    //          to  ro   tf  rf   lat     orient res  nm chk_res
    vecs[0]  = '{2,  50,  2,  80,  SC_LAT, 5,     0,   0, 1};
    vecs[1]  = '{2,  80,  2,  50,  SC_LAT, 17,    0,   0, 1};
    vecs[2]  = '{0,  100, 5,  100, 6,      12,    0,   0, 1};
    vecs[3]  = '{0,  0,   1,  100, 12,     3,     0,   0, 1};
    vecs[4]  = '{0,  0,   3,  3,   6,      3,     0,   1, 0};
    vecs[5]  = '{0,  0,   10, 100, 12,     21,    0,   0, 1};
    vecs[6]  = '{0,  0,   4,  100, 12,     9,     0,   0, 1};
    vecs[7]  = '{1,  100, 10, 100, 6,      18,    0,   0, 1};
    vecs[8]  = '{0,  100, 11, 97,  6,      18,    3,   0, 1};
    vecs[9]  = '{5,  100, 0,  90,  6,      0,     3,   0, 1};
    vecs[10] = '{9,  230, 2,  255, 12,     5,     255, 0, 1};
    vecs[11] = '{1,  16,  2,  20,  12,     9,     2,   0, 1};
    vecs[12] = '{0,  0,   3,  3,   6,      9,     0,   1, 0};

    for (int i = 0; i < 13; i++) begin
      run(vecs[i].to, vecs[i].ro, vecs[i].tf, vecs[i].rf, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_orientation", i), orientation, vecs[i].orient);
      if (vecs[i].chk_res != 0)
        check($sformatf("v%0d_residual", i), residual, vecs[i].res);
      check($sformatf("v%0d_no_motion", i), no_motion, vecs[i].nm);
      check($sformatf("v%0d_busy_at_done", i), busy, 0);
    end

    // Reset sampled on edge 8 of a general run.
    r_theta_original = {4'd0, 8'd0};
    r_theta_final    = {4'd1, 8'd100};
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_done", done, 0);
    check("midrun_reset_orientation", orientation, 0);
    check("midrun_reset_residual", residual, 0);
    check("midrun_reset_no_motion", no_motion, 0);
    reset = 1'b0;
    tick();
    check("after_reset_idle_busy", busy, 0);
    check("after_reset_idle_done", done, 0);

    // Enable pulse while busy must not restart or stretch the run.
    r_theta_original = {4'd0, 8'd0};
    r_theta_final    = {4'd4, 8'd100};
    enable = 1'b1;
    tick();
    enable = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 3) enable = 1'b1;
      if (lat == 4) enable = 1'b0;
    end while (!done && lat < 40);
    check("busy_enable_latency", lat, 12);
    check("busy_enable_orientation", orientation, 9);
    tick();
    check("done_held_busy", busy, 0);
    check("done_held_done", done, 1);

    // Reset wins over a simultaneous enable.
    reset = 1'b1;
    enable = 1'b1;
    tick();
    check("rst_prio_busy", busy, 0);
    check("rst_prio_done", done, 0);
    reset = 1'b0;
    enable = 1'b0;
    tick();
    check("rst_prio_stays_idle", busy, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
